// File: rtl/alu_byte_sequencer_pkg.sv
// Shared definitions for the byte-serial ALU sequencer: function-code width and
// constants, the sequencer FSM state type, and an index-width helper.
package alu_pkg;

    localparam int ALU_FUNC_W = 3;

    localparam logic [ALU_FUNC_W-1:0] ALU_ADD = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } alu_seq_state_t;

    // Byte-index counter width; a 1-byte word still needs one bit to hold index 0.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_byte_sequencer_if.sv
// Bundles the command, ALU and response channels of the sequencer.
// slave  : the sequencer's view.
// master : the surrounding controller/ALU view.
interface alu_byte_sequencer_if
    import alu_pkg::*;
#(
    parameter int BYTES = 2
);
    localparam int W = 8 * BYTES;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [W-1:0]          cmd_a;
    logic [W-1:0]          cmd_b;
    logic [ALU_FUNC_W-1:0] cmd_func;
    logic                  cmd_ci;

    logic [7:0]            alu_a;
    logic [7:0]            alu_b;
    logic                  alu_ci;
    logic [ALU_FUNC_W-1:0] alu_func;
    logic [7:0]            alu_result;
    logic                  alu_co;
    logic                  alu_zero;
    logic                  alu_neg;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [W-1:0]          rsp_result;
    logic                  rsp_co;
    logic                  rsp_zero;
    logic                  rsp_neg;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_func, cmd_ci,
        output cmd_ready,
        output alu_a, alu_b, alu_ci, alu_func,
        input  alu_result, alu_co, alu_zero, alu_neg,
        output rsp_valid, rsp_result, rsp_co, rsp_zero, rsp_neg,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_func, cmd_ci,
        input  cmd_ready,
        input  alu_a, alu_b, alu_ci, alu_func,
        output alu_result, alu_co, alu_zero, alu_neg,
        input  rsp_valid, rsp_result, rsp_co, rsp_zero, rsp_neg,
        output rsp_ready
    );

endinterface

// File: rtl/alu_byte_sequencer_flag_acc.sv
// alu_flag_acc: folds per-byte ALU flags into word flags.
// carry chains carryOut into the next byte, zacc ANDs the per-byte zero flags,
// nflag keeps the sign of the most significant byte.
module alu_flag_acc (
    input  logic clk,
    input  logic clr,    // synchronous clear of all accumulators
    input  logic load,   // start of a new word
    input  logic ci,     // carry into byte 0
    input  logic step,   // one byte processed this cycle
    input  logic last,   // the byte being processed is the MSB
    input  logic co,
    input  logic zero,
    input  logic neg,
    output logic carry,
    output logic zacc,
    output logic nflag
);

    // Accumulate flags; clear beats load beats step.
    always_ff @(posedge clk) begin
        if (clr) begin
            carry <= 1'b0;
            zacc  <= 1'b0;
            nflag <= 1'b0;
        end else if (load) begin
            carry <= ci;
            zacc  <= 1'b1;
        end else if (step) begin
            carry <= co;
            zacc  <= zacc & zero;
            if (last) nflag <= neg;
        end
    end

endmodule

// File: rtl/alu_byte_sequencer.sv
// alu_byte_sequencer: issues a BYTES-wide operation to an 8-bit ALU one byte
// per cycle, LSB first, chaining carry, and returns the assembled word + flags.
// Optional feature macro: ALU_SEQ_PIPE_EN (accept the next command in the same
// cycle the response is taken, skipping IDLE).
module alu_byte_sequencer
    import alu_pkg::*;
#(
    parameter int BYTES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_byte_sequencer_if.slave  bus
);

    localparam int              IW   = idx_width(BYTES);
    localparam logic [IW-1:0]   LAST = IW'(BYTES - 1);

    alu_seq_state_t             state, state_nxt;
    logic [BYTES-1:0][7:0]      a_q, b_q, res_q;
    logic [ALU_FUNC_W-1:0]      func_q;
    logic [IW-1:0]              idx;
    logic                       cmd_hs, in_run, run_last;
    logic                       carry, zacc, nflag;

    assign cmd_hs   = bus.cmd_valid & bus.cmd_ready;
    assign in_run   = (state == S_RUN);
    assign run_last = in_run & (idx == LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: IDLE->RUN on accept, RUN->DONE after the MSB, DONE leaves on rsp handshake.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (cmd_hs)        state_nxt = S_RUN;
            S_RUN:   if (idx == LAST)   state_nxt = S_DONE;
            S_DONE:  if (bus.rsp_ready) state_nxt = cmd_hs ? S_RUN : S_IDLE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    // Outputs: ALU driven only in RUN; response valid only in DONE.
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_ci    = 1'b0;
        bus.alu_func  = '0;
        unique case (state)
            S_IDLE: bus.cmd_ready = 1'b1;
            S_RUN: begin
                bus.alu_a    = a_q[idx];
                bus.alu_b    = b_q[idx];
                bus.alu_ci   = carry;
                bus.alu_func = func_q;
            end
            S_DONE: begin
                bus.rsp_valid = 1'b1;
`ifdef ALU_SEQ_PIPE_EN
                bus.cmd_ready = bus.rsp_ready;
`else
                bus.cmd_ready = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    // Operand latch at accept, then per-byte result capture and index advance in RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            func_q <= ALU_ADD;
            idx    <= '0;
            res_q  <= '0;
        end else if (cmd_hs) begin
            a_q    <= bus.cmd_a;
            b_q    <= bus.cmd_b;
            func_q <= bus.cmd_func;
            idx    <= '0;
        end else if (in_run) begin
            res_q[idx] <= bus.alu_result;
            idx        <= run_last ? '0 : idx + 1'b1;
        end
    end

    alu_flag_acc u_flags (
        .clk   (clk),
        .clr   (~rst_n),
        .load  (cmd_hs),
        .ci    (bus.cmd_ci),
        .step  (in_run),
        .last  (run_last),
        .co    (bus.alu_co),
        .zero  (bus.alu_zero),
        .neg   (bus.alu_neg),
        .carry (carry),
        .zacc  (zacc),
        .nflag (nflag)
    );

    assign bus.rsp_result = res_q;
    assign bus.rsp_co     = carry;
    assign bus.rsp_zero   = zacc;
    assign bus.rsp_neg    = nflag;

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Directed bench for alu_byte_sequencer (BYTES=2) with a behavioural 8-bit ALU:
// func 000 = a+b+ci, func 101 = a^b (co=0), others produce 0.
module tb_alu_byte_sequencer;
    import alu_pkg::*;

`ifdef ALU_SEQ_PIPE_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    alu_byte_sequencer_if #(.BYTES(2)) bus ();

    alu_byte_sequencer #(.BYTES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural ALU, combinational.
    logic [8:0] sum;
    always_comb begin
        sum            = 9'(bus.alu_a) + 9'(bus.alu_b) + 9'(bus.alu_ci);
        bus.alu_result = 8'h00;
        bus.alu_co     = 1'b0;
        case (bus.alu_func)
            ALU_ADD: {bus.alu_co, bus.alu_result} = sum;
            3'b101:  bus.alu_result = bus.alu_a ^ bus.alu_b;
            default: ;
        endcase
        bus.alu_zero = (bus.alu_result == 8'h00);
        bus.alu_neg  = bus.alu_result[7];
    end

    typedef struct {
        logic [15:0] a, b;
        logic [2:0]  func;
        logic        ci, ci1;
        logic [15:0] res;
        logic        co, zero, neg;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        bus.cmd_a    = v.a;
        bus.cmd_b    = v.b;
        bus.cmd_func = v.func;
        bus.cmd_ci   = v.ci;
    endtask

    // One full transaction: accept, per-byte ALU drive, latency, response, optional stall.
    task automatic run_vec(input vec_t v, input int stall, input string tag);
        int n;
        @(negedge clk);
        drive_cmd(v);
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        #1;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin @(negedge clk); #1; n++; end
        chk({tag, " cmd_ready"}, 32'(bus.cmd_ready), 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_a = 16'hDEAD; bus.cmd_b = 16'hBEEF; bus.cmd_ci = ~v.ci; bus.cmd_func = 3'b111;
        #1;
        chk({tag, " alu_a0"},   32'(bus.alu_a),    32'(v.a[7:0]));
        chk({tag, " alu_b0"},   32'(bus.alu_b),    32'(v.b[7:0]));
        chk({tag, " alu_ci0"},  32'(bus.alu_ci),   32'(v.ci));
        chk({tag, " alu_func"}, 32'(bus.alu_func), 32'(v.func));
        @(negedge clk); #1;
        chk({tag, " alu_a1"},   32'(bus.alu_a),    32'(v.a[15:8]));
        chk({tag, " alu_b1"},   32'(bus.alu_b),    32'(v.b[15:8]));
        chk({tag, " alu_ci1"},  32'(bus.alu_ci),   32'(v.ci1));
        n = 1;
        while (!bus.rsp_valid && n < 10) begin @(negedge clk); #1; n++; end
        chk({tag, " latency"}, n, 2);
        chk({tag, " result"},  32'(bus.rsp_result), 32'(v.res));
        chk({tag, " co"},      32'(bus.rsp_co),     32'(v.co));
        chk({tag, " zero"},    32'(bus.rsp_zero),   32'(v.zero));
        chk({tag, " neg"},     32'(bus.rsp_neg),    32'(v.neg));
        chk({tag, " alu_idle"}, {bus.alu_a, bus.alu_b, 5'(bus.alu_func), 1'(bus.alu_ci)}, 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk); #1;
            chk({tag, " hold valid"},  32'(bus.rsp_valid),  1);
            chk({tag, " hold result"}, 32'(bus.rsp_result), 32'(v.res));
            chk({tag, " hold flags"},  {bus.rsp_co, bus.rsp_zero, bus.rsp_neg}, {v.co, v.zero, v.neg});
            chk({tag, " hold cmd_rdy"}, 32'(bus.cmd_ready), 0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        chk({tag, " post valid"}, 32'(bus.rsp_valid), 0);
        chk({tag, " post ready"}, 32'(bus.cmd_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   g;
        logic hs;
        //        a         b         func    ci    ci1   res       co    zero  neg
        vt[0] = '{16'h00FF, 16'h0001, 3'b000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 3'b000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
        vt[2] = '{16'h7FFF, 16'h0000, 3'b000, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b1};
        vt[3] = '{16'h1234, 16'h4321, 3'b000, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vt[4] = '{16'h00FF, 16'h0000, 3'b000, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0};
        vt[5] = '{16'h8000, 16'h8000, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        vt[6] = '{16'h0F0F, 16'hFFFF, 3'b101, 1'b1, 1'b0, 16'hF0F0, 1'b0, 1'b0, 1'b1};
        vt[7] = '{16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};

        bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
        bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_func = '0; bus.cmd_ci = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset cmd_ready", 32'(bus.cmd_ready), 1);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 0);
        chk("reset rsp",  {bus.rsp_result, 13'd0, bus.rsp_co, bus.rsp_zero, bus.rsp_neg}, 0);
        chk("reset alu",  {bus.alu_a, bus.alu_b, 5'(bus.alu_func), 1'(bus.alu_ci)}, 0);

        for (int i = 0; i < 8; i++) run_vec(vt[i], 0, $sformatf("v%0d", i));

        // Response back-pressure for 5 cycles.
        run_vec(vt[0], 5, "stall");

        // Reset mid-RUN aborts the operation.
        @(negedge clk);
        drive_cmd(vt[0]);
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #1;
        chk("abort in run", 32'(bus.alu_a), 32'h00FF);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort cmd_ready", 32'(bus.cmd_ready), 1);
        chk("abort rsp_valid", 32'(bus.rsp_valid), 0);
        chk("abort rsp",  {bus.rsp_result, 13'd0, bus.rsp_co, bus.rsp_zero, bus.rsp_neg}, 0);
        chk("abort alu",  {bus.alu_a, bus.alu_b, 5'(bus.alu_func), 1'(bus.alu_ci)}, 0);
        hs = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            hs = hs | bus.rsp_valid;
        end
        chk("abort no rsp", 32'(hs), 0);

        // Back-to-back commands: measure gap from first response handshake.
        @(negedge clk);
        drive_cmd(vt[0]);
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        g = 0;
        #1;
        while (!bus.rsp_valid && g < 10) begin @(negedge clk); #1; g++; end
        chk("b2b first result", 32'(bus.rsp_result), 32'h0100);
        drive_cmd(vt[1]);
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        hs = bus.cmd_valid & bus.cmd_ready;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        if (hs) bus.cmd_valid = 1'b0;
        #1;
        chk("b2b first taken", 32'(bus.rsp_valid), 0);
        g = 0;
        while (!bus.rsp_valid && g < 10) begin
            hs = bus.cmd_valid & bus.cmd_ready;
            @(negedge clk);
            g++;
            if (hs) bus.cmd_valid = 1'b0;
            #1;
        end
        chk("b2b gap", g, GAP);
        chk("b2b second result", 32'(bus.rsp_result), 32'h0000);
        chk("b2b second flags", {bus.rsp_co, bus.rsp_zero, bus.rsp_neg}, 3'b110);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        chk("b2b end idle", 32'(bus.cmd_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
